// File: rtl/alu_mc.sv
// alu_mc: multi-cycle, handshaked ALU execution unit.
// A request (a, b, aluc) is accepted over a valid/ready channel.
// The registered result r and zero flag z are returned over a second valid/ready channel.
// Shifts are performed one bit position per cycle.
// Optional build macro ALU_MC_BARREL_EN replaces the iterative shifter with a single-cycle barrel shifter.
// With the macro defined, every opcode has latency 1.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SAW   = 5
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       aluc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             z,
   output logic             busy
);

`ifdef ALU_MC_BARREL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

   state_t           state, state_nxt;
   logic [SAW-1:0]   sa;
   logic             is_shift;
   logic [WIDTH-1:0] alu_res;

   assign sa       = a[SAW-1:0];
   assign is_shift = (aluc[1:0] == 2'b11);

`ifndef ALU_MC_BARREL_EN
   logic [WIDTH-1:0] work;
   logic [SAW-1:0]   count;
   logic [1:0]       mode;      // aluc[3:2] of the shift in flight
   logic [WIDTH-1:0] step;
   logic             last_step;

   assign last_step = (count == SAW'(1));

   // One-position shift of the working register; SRA replicates the sign bit.
   always_comb begin
      step = {work[WIDTH-2:0], 1'b0};
      case (mode)
         2'b01:   step = {1'b0, work[WIDTH-1:1]};
         2'b11:   step = {work[WIDTH-1], work[WIDTH-1:1]};
         default: step = {work[WIDTH-2:0], 1'b0};
      endcase
   end
`endif

   // Result of the accepted op when it completes in the accept cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      alu_res = '0;
      case (aluc[2:0])
         3'b000: alu_res = a + b;
         3'b100: alu_res = a - b;
         3'b001: alu_res = a & b;
         3'b101: alu_res = a | b;
         3'b010: alu_res = a ^ b;
         3'b110: alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         default: begin
`ifdef ALU_MC_BARREL_EN
            case (aluc[3:2])
               2'b01:   alu_res = b >> sa;
               2'b11:   alu_res = $signed(b) >>> sa;
               default: alu_res = b << sa;
            endcase
`else
            // Only a zero-amount shift completes here; the result is b unchanged.
            alu_res = b;
`endif
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge clrn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
`ifdef ALU_MC_BARREL_EN
               state_nxt = DONE;
`else
               state_nxt = (is_shift && (sa != '0)) ? SHIFT : DONE;
`endif
            end
         end
`ifndef ALU_MC_BARREL_EN
         SHIFT: if (last_step) state_nxt = DONE;
`endif
         DONE:  if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

`ifdef ALU_MC_BARREL_EN
   // Result register: written only on accept, held through DONE.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r <= '0;
         z <= 1'b1;
      end else if (state == IDLE && in_valid) begin
         r <= alu_res;
         z <= (alu_res == '0);
      end
   end
`else
   // Result register and iterative shifter; z is taken only from a final result.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r     <= '0;
         z     <= 1'b1;
         work  <= '0;
         count <= '0;
         mode  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift && (sa != '0)) begin
                     work  <= b;
                     count <= sa;
                     mode  <= aluc[3:2];
                  end else begin
                     r <= alu_res;
                     z <= (alu_res == '0);
                  end
               end
            end
            SHIFT: begin
               work  <= step;
               count <= count - SAW'(1);
               if (last_step) begin
                  r <= step;
                  z <= (step == '0);
               end
            end
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven directed test of alu_mc, plus hand-written
// backpressure, held-off request and mid-shift reset sequences.
module tb_alu_mc;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          clrn;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [3:0]    aluc;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  r;
   logic          z;
   logic          busy;

   int tests = 0;
   int fails = 0;

   alu_mc #(.WIDTH(W), .SAW(5)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .aluc      (aluc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .z         (z),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   aluc;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         z;
      int           lat;   // iterative-build latency in cycles after accept
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input int l);
`ifdef ALU_MC_BARREL_EN
      return (l > 0) ? 1 : 1;
`else
      return l;
`endif
   endfunction

   // Issue one op, wait (bounded) for out_valid, then complete the response handshake.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         output logic [W-1:0] rr, output logic zz, output int lat);
      @(negedge clk);
      in_valid = 1'b1;
      aluc     = op;
      a        = aa;
      b        = bb;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      rr = r;
      zz = z;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   logic [W-1:0] rr;
   logic         zz;
   int           lat;

   initial begin
      vecs.push_back('{4'b0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1});
      vecs.push_back('{4'b0100, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1});
      vecs.push_back('{4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
      vecs.push_back('{4'b0001, 32'hCCCC_CCCC, 32'hAAAA_AAAA, 32'h8888_8888, 1'b0, 1});
      vecs.push_back('{4'b0101, 32'hCCCC_CCCC, 32'hAAAA_AAAA, 32'hEEEE_EEEE, 1'b0, 1});
      vecs.push_back('{4'b0010, 32'hCCCC_CCCC, 32'hAAAA_AAAA, 32'h6666_6666, 1'b0, 1});
      vecs.push_back('{4'b0110, 32'h0000_0000, 32'hFF00_5555, 32'h5555_0000, 1'b0, 1});
      vecs.push_back('{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1});
      vecs.push_back('{4'b1100, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1});
      vecs.push_back('{4'b1010, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1});
      vecs.push_back('{4'b1110, 32'h0000_0000, 32'h1234_ABCD, 32'hABCD_0000, 1'b0, 1});
      vecs.push_back('{4'b0011, 32'h0000_000F, 32'hFFFF_FFFF, 32'hFFFF_8000, 1'b0, 16});
      vecs.push_back('{4'b0111, 32'h0000_000F, 32'hFFFF_FFFF, 32'h0001_FFFF, 1'b0, 16});
      vecs.push_back('{4'b1111, 32'h0000_0010, 32'h7F00_0000, 32'h0000_7F00, 1'b0, 17});
      vecs.push_back('{4'b1111, 32'h0000_0010, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b0, 17});
      vecs.push_back('{4'b1111, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1});
      vecs.push_back('{4'b1011, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 2});
      vecs.push_back('{4'b0011, 32'h0000_001F, 32'h0000_0001, 32'h8000_0000, 1'b0, 32});
      vecs.push_back('{4'b0111, 32'h0000_001F, 32'h8000_0000, 32'h0000_0001, 1'b0, 32});
      vecs.push_back('{4'b1111, 32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32});
      vecs.push_back('{4'b0111, 32'hFFFF_FFE4, 32'h0000_00F0, 32'h0000_000F, 1'b0, 5});
      vecs.push_back('{4'b0011, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b1, 2});

      clrn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      aluc      = '0;
      repeat (3) @(negedge clk);

      // Reset state, observed while clrn is still low.
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst r", r, 32'h0);
      check("rst z", 32'(z), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      clrn = 1'b1;
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd1);

      // out_ready while nothing is pending has no effect.
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle out_ready in_ready", 32'(in_ready), 32'd1);
      check("idle out_ready out_valid", 32'(out_valid), 32'd0);

      // Table-driven vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].aluc, vecs[i].a, vecs[i].b, rr, zz, lat);
         check($sformatf("vec%0d r", i), rr, vecs[i].r);
         check($sformatf("vec%0d z", i), 32'(zz), 32'(vecs[i].z));
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i].lat)));
         check($sformatf("vec%0d idle after handshake", i), 32'({out_valid, in_ready}), 32'b01);
      end

      // Backpressure: ADD 1+2 held in DONE for 5 cycles while a SUB request waits.
      @(negedge clk);
      in_valid = 1'b1;
      aluc     = 4'b0000;
      a        = 32'd1;
      b        = 32'd2;
      @(posedge clk);
      @(negedge clk);
      aluc = 4'b0100;               // held-off request, kept stable until accepted
      check("bp first out_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp hold r %0d", k), r, 32'd3);
         check($sformatf("bp hold z/in_ready/out_valid %0d", k), 32'({z, in_ready, out_valid}), 32'b001);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp release out_valid/in_ready", 32'({out_valid, in_ready}), 32'b01);
      // The waiting SUB 1-2 is accepted at the next edge.
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("held SUB r", r, 32'hFFFF_FFFF);
      check("held SUB latency", 32'(lat), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset mid-shift: SLL sa=20, clrn dropped 5 cycles after accept.
      @(negedge clk);
      in_valid = 1'b1;
      aluc     = 4'b0011;
      a        = 32'd20;
      b        = 32'd1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("mid-op busy", 32'(busy), 32'd1);
      #1 clrn = 1'b0;
      #1;
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst r", r, 32'h0);
      check("async rst z/busy", 32'({z, busy}), 32'b10);
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      check("post rst in_ready", 32'(in_ready), 32'd1);
      repeat (25) @(negedge clk);
      check("discarded op no out_valid", 32'(out_valid), 32'd0);
      run_op(4'b0000, 32'd1, 32'd2, rr, zz, lat);
      check("post rst ADD r", rr, 32'd3);
      check("post rst ADD latency", 32'(lat), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Multi-cycle, handshaked ALU execution unit. It accepts one operation at a time over a valid/ready request channel and returns the result and zero flag over a valid/ready response channel. Opcodes and semantics match the team's combinational ALU. Shifts are performed iteratively, one bit position per cycle. It sits between the multi-cycle CPU control unit and the register-file writeback path.

Parameters:
WIDTH, 32, datapath width; must be an even power of two, at least 8.
SAW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
clk  input  1  rising-edge clock.
clrn  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request; high only in IDLE.
a  input  WIDTH  operand A; a[SAW-1:0] is the shift amount for shifts.
b  input  WIDTH  operand B; the shifted operand for shifts.
aluc  input  4  opcode.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
r  output  WIDTH  registered result.
z  output  1  registered flag, (r == 0).
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Opcodes (x = don't care):
  - x000 ADD a+b; x100 SUB a-b (both modulo 2^WIDTH, no carry/overflow out).
  - x001 AND; x101 OR; x010 XOR.
  - x110 LUI: r = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 0011 and 1011 SLL b by sa; 0111 SRL b by sa (zero fill); 1111 SRA b by sa (sign fill from b[WIDTH-1]).
- Request handshake: accepted on a rising edge where in_valid && in_ready. a, b and aluc are captured on that edge. Inputs are ignored at all other times.
- State machine, with states IDLE, SHIFT and DONE:
  - IDLE, accept of a non-shift op: r and z written, go to DONE. out_valid is high the cycle after accept (latency 1).
  - IDLE, accept of a shift with sa=0: r=b, go to DONE (latency 1).
  - IDLE, accept of a shift with sa>0: working register = b, count = sa, go to SHIFT.
  - SHIFT: each cycle, shift the working register one position and decrement count. On the cycle count reaches 0, write r and z and go to DONE. out_valid rises sa+1 cycles after accept; for example sa=31 gives 32 cycles.
  - DONE: out_valid=1. r and z are held stable while out_valid && !out_ready. On out_valid && out_ready, go to IDLE.
- No back-to-back issue: in_ready is low in DONE even during the handshake cycle. The next accept can happen one cycle after the response handshake. Maximum throughput is one op per 2 cycles.
- in_valid asserted in SHIFT or DONE: held off, no state change. The requester keeps its request stable until accepted.
- out_ready asserted while out_valid=0: no effect.
- Reset (clrn=0, any time including mid-shift or while holding a result): the in-flight op is discarded. State=IDLE, r=0, z=1, out_valid=0, busy=0, count=0. in_ready=1 once clrn is high.
- z is always computed from the final r, never from an intermediate shift value.

Optional Feature:
ALU_MC_BARREL_EN
- Defined: shifts use a single-cycle barrel shifter. Every opcode has latency 1. SHIFT state and count logic are not generated; busy is high only in DONE.
- Undefined: iterative shifting as specified above. Results are bit-identical in both builds; only latency differs.

Test Plan:
- ADD a=1, b=2: r=3, z=0, out_valid high 1 cycle after accept. Then SUB a=1, b=2: r=FFFFFFFF, z=0.
- SUB a=FFFFFFFF, b=FFFFFFFF: r=0, z=1. AND a=CCCCCCCC, b=AAAAAAAA: r=88888888. OR on the same operands: r=EEEEEEEE. LUI b=FF005555: r=55550000.
- SLL a=F, b=FFFFFFFF: r=FFFF8000, out_valid 16 cycles after accept. SRL with the same operands: r=0001FFFF. With ALU_MC_BARREL_EN, both have latency 1.
- SRA a=10, b=7F000000: r=00007F00. SRA a=10, b=FFFFFF00: r=FFFFFFFF, latency 17. SRA sa=0, b=80000000: r=80000000, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid; r and z stay stable and in_ready stays 0. Assert out_ready: out_valid drops next cycle and in_ready rises the same cycle.
- Drop clrn to 0 mid-SHIFT (SLL sa=20, after 5 cycles): out_valid stays 0, r=0, z=1, in_ready=1 after release. A fresh ADD 1+2 then returns 3.
